// File: rtl/iq_power_avg.sv
//==============================================================================
// Module      : iq_power_avg
// Description : Block-averaged I/Q power, mean(I^2+Q^2) over 2^LOG2_AVG samples,
//               handed to a non-pipelined square-root stage via en/dav.
//               Optional macro IQ_POWER_AVG_ROUND_EN: round half up and saturate.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module iq_power_avg #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_AVG   = 4,
  parameter int X_WIDTH    = 2*DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic signed [DATA_WIDTH-1:0] q_data,
  input  logic                         valid,
  output logic [X_WIDTH-1:0]           sqrt_x,
  output logic                         sqrt_en,
  input  logic                         sqrt_dav,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         overrun_clr
);

  localparam int c_DW2 = 2*DATA_WIDTH;
  localparam int c_AW  = c_DW2 + LOG2_AVG;
  localparam int c_CW  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'((2**LOG2_AVG) - 1);
`ifdef IQ_POWER_AVG_ROUND_EN
  localparam int c_WW  = (X_WIDTH > c_AW+1) ? X_WIDTH : c_AW+1;
  localparam logic [c_AW:0] c_HALF = (c_AW+1)'((2**LOG2_AVG)/2);
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Input capture and validity tags for each pipeline stage
  logic signed [DATA_WIDTH-1:0] r_i;
  logic signed [DATA_WIDTH-1:0] r_q;
  logic                         r_v0;
  logic                         r_v1;
  logic                         r_v2;
  logic [c_DW2-1:0]             r_isq;
  logic [c_DW2-1:0]             r_qsq;
  logic [c_DW2-1:0]             r_sum;
  logic [c_AW-1:0]              r_acc;
  logic [c_CW-1:0]              r_cnt;
  logic [X_WIDTH-1:0]           r_hold;
  logic                         r_pending;
  logic                         r_overrun;
  logic [X_WIDTH-1:0]           r_x;
  logic                         r_en;
  state_t                       r_state;
  state_t                       w_state_nxt;

  logic signed [c_DW2-1:0] w_i_ext;
  logic signed [c_DW2-1:0] w_q_ext;
  logic signed [c_DW2-1:0] w_isq;
  logic signed [c_DW2-1:0] w_qsq;
  logic [c_AW:0]           w_total;
  logic [c_AW:0]           w_shifted;
  logic [X_WIDTH-1:0]      w_mean;
  logic                    w_last;
  logic                    w_new;
  logic                    w_dispatch;

  // Sign-extend before squaring so the most negative input cannot overflow
  assign w_i_ext = {{DATA_WIDTH{r_i[DATA_WIDTH-1]}}, r_i};
  assign w_q_ext = {{DATA_WIDTH{r_q[DATA_WIDTH-1]}}, r_q};
  assign w_isq   = w_i_ext * w_i_ext;
  assign w_qsq   = w_q_ext * w_q_ext;

`ifdef IQ_POWER_AVG_ROUND_EN
  logic [c_WW-1:0] w_wide;
  assign w_total   = {1'b0, r_acc} + (c_AW+1)'(r_sum) + c_HALF;
  assign w_shifted = w_total >> LOG2_AVG;
  assign w_wide    = c_WW'(w_shifted);
  assign w_mean    = (|(w_wide >> X_WIDTH)) ? {X_WIDTH{1'b1}} : w_wide[X_WIDTH-1:0];
`else
  assign w_total   = {1'b0, r_acc} + (c_AW+1)'(r_sum);
  assign w_shifted = w_total >> LOG2_AVG;
  assign w_mean    = X_WIDTH'(w_shifted);
`endif

  assign w_last     = (r_cnt == c_LAST);
  assign w_new      = r_v2 && w_last;
  assign w_dispatch = (r_state == S_IDLE) && r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i   <= '0;
      r_q   <= '0;
      r_v0  <= 1'b0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_isq <= '0;
      r_qsq <= '0;
      r_sum <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      r_v0 <= valid;
      r_v1 <= r_v0;
      r_v2 <= r_v1;
      if (valid) begin
        r_i <= i_data;
        r_q <= q_data;
      end
      if (r_v0) begin
        r_isq <= $unsigned(w_isq);
        r_qsq <= $unsigned(w_qsq);
      end
      if (r_v1) begin
        r_sum <= r_isq + r_qsq;
      end
      // Block boundary restarts accumulation on the same edge, no idle gap
      if (r_v2) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= r_acc + c_AW'(r_sum);
          r_cnt <= r_cnt + c_CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_x       <= '0;
      r_en      <= 1'b0;
    end else begin
      r_en <= w_dispatch;
      if (w_dispatch) begin
        r_x <= r_hold;
      end
      if (w_new) begin
        r_hold    <= w_mean;
        r_pending <= 1'b1;
      end else if (w_dispatch) begin
        r_pending <= 1'b0;
      end
      // A fresh overrun wins over a simultaneous clear
      if (w_new && r_pending && !w_dispatch) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_pending) w_state_nxt = S_WAIT;
      S_WAIT: if (sqrt_dav)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sqrt_x  = r_x;
  assign sqrt_en = r_en;
  assign busy    = (r_state == S_WAIT);
  assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_iq_power_avg.sv
//==============================================================================
// Module      : tb_iq_power_avg
// Description : Directed self-checking bench for iq_power_avg (LOG2_AVG = 2).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iq_power_avg;

  localparam int DW = 16;
  localparam int L2 = 2;
  localparam int XW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] i_data;
  logic signed [DW-1:0] q_data;
  logic                 valid;
  logic [XW-1:0]        sqrt_x;
  logic                 sqrt_en;
  logic                 sqrt_dav;
  logic                 busy;
  logic                 overrun;
  logic                 overrun_clr;

  int            total  = 0;
  int            bad    = 0;
  int            en_cnt = 0;
  int            e0;
  logic [XW-1:0] last_x = '0;
  logic [63:0]   exp_trunc;

  iq_power_avg #(
    .DATA_WIDTH(DW),
    .LOG2_AVG  (L2),
    .X_WIDTH   (XW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .q_data     (q_data),
    .valid      (valid),
    .sqrt_x     (sqrt_x),
    .sqrt_en    (sqrt_en),
    .sqrt_dav   (sqrt_dav),
    .busy       (busy),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (sqrt_en) begin
      en_cnt++;
      last_x = sqrt_x;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int iv, input int qv);
    i_data = DW'(iv);
    q_data = DW'(qv);
    valid  = 1'b1;
    tick();
    valid  = 1'b0;
  endtask

  task automatic wait_en(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (sqrt_en) seen = 1'b1;
    end
    chk(tag, {63'd0, seen}, 64'd1);
  endtask

  task automatic dav_pulse(input string tag);
    sqrt_dav = 1'b1;
    tick();
    sqrt_dav = 1'b0;
    chk(tag, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; i_data = '0; q_data = '0; valid = 1'b0;
    sqrt_dav = 1'b0; overrun_clr = 1'b0;
`ifdef IQ_POWER_AVG_ROUND_EN
    exp_trunc = 64'd1;
`else
    exp_trunc = 64'd0;
`endif
    repeat (3) tick();
    rst = 1'b0;

    // Reset state with random inputs and valid low
    for (int n = 0; n < 8; n++) begin
      i_data = DW'($urandom);
      q_data = DW'($urandom);
      tick();
    end
    chk("rst_en",      {63'd0, sqrt_en}, 64'd0);
    chk("rst_busy",    {63'd0, busy},    64'd0);
    chk("rst_overrun", {63'd0, overrun}, 64'd0);
    chk("rst_x",       64'(sqrt_x),      64'd0);
    chk("rst_en_cnt",  64'(en_cnt),      64'd0);

    // Basic block 3/4 -> 25, exact latency, dav 17 cycles after en
    e0 = en_cnt;
    repeat (4) send(3, 4);
    repeat (3) tick();
    chk("t1_no_early_en", {63'd0, sqrt_en}, 64'd0);
    tick();
    chk("t1_en",   {63'd0, sqrt_en}, 64'd1);
    chk("t1_x",    64'(sqrt_x),      64'd25);
    chk("t1_busy", {63'd0, busy},    64'd1);
    repeat (16) tick();
    chk("t1_busy_hold", {63'd0, busy},   64'd1);
    chk("t1_one_en",    64'(en_cnt - e0), 64'd1);
    dav_pulse("t1_idle_after_dav");
    tick();
    chk("t1_no_redispatch", 64'(en_cnt - e0), 64'd1);

    // Extremes: most negative I and Q
    repeat (4) send(-32768, -32768);
    wait_en("t2_en_seen", 12);
    chk("t2_x", 64'(sqrt_x), 64'h8000_0000);
    dav_pulse("t2_idle");

    // Truncation versus rounding
    send(1, 0); send(1, 0); send(1, 0); send(0, 0);
    wait_en("t3_en_seen", 12);
    chk("t3_x", 64'(sqrt_x), exp_trunc);
    dav_pulse("t3_idle");

    // Overrun: three back-to-back blocks, dav withheld
    e0 = en_cnt;
    repeat (4) send(1, 0);
    repeat (4) send(2, 0);
    repeat (4) send(3, 0);
    repeat (4) tick();
    chk("t4_one_en",  64'(en_cnt - e0),   64'd1);
    chk("t4_first_x", 64'(last_x),        64'd1);
    chk("t4_overrun", {63'd0, overrun},   64'd1);
    chk("t4_busy",    {63'd0, busy},      64'd1);
    dav_pulse("t4_idle");
    tick();
    chk("t4_en2",      {63'd0, sqrt_en},  64'd1);
    chk("t4_x2",       64'(sqrt_x),       64'd9);
    chk("t4_two_en",   64'(en_cnt - e0),  64'd2);
    chk("t4_ovr_keep", {63'd0, overrun},  64'd1);
    dav_pulse("t4_idle2");
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("t4_ovr_clr", {63'd0, overrun}, 64'd0);

    // Reset during WAIT, stray dav, then normal operation
    repeat (4) send(3, 4);
    wait_en("t5_en_seen", 12);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy_rst", {63'd0, busy}, 64'd0);
    chk("t5_x_rst",    64'(sqrt_x),   64'd0);
    e0 = en_cnt;
    sqrt_dav = 1'b1;
    tick();
    sqrt_dav = 1'b0;
    repeat (6) tick();
    chk("t5_no_en",   64'(en_cnt - e0), 64'd0);
    chk("t5_busy_lo", {63'd0, busy},    64'd0);
    repeat (4) send(5, 12);
    wait_en("t5_en2_seen", 12);
    chk("t5_x2", 64'(sqrt_x), 64'd169);
    dav_pulse("t5_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iq_power_avg.md
Name: iq_power_avg

Overview:
- Upstream feeder for the integer square-root stage: converts signed I/Q ADC samples into block-averaged power, mean(I^2 + Q^2) over 2^LOG2_AVG samples.
- Hands each mean to the non-pipelined square-root stage with an en/dav handshake, so the downstream output is RMS magnitude.
- Holds one pending result, never cancels an in-flight root, and flags overruns.

Parameters:
- DATA_WIDTH, 16: signed I/Q sample width.
- LOG2_AVG, 4: log2 of block length; 0 allowed (every sample is a block).
- X_WIDTH, 2*DATA_WIDTH: width of mean passed downstream; must be even.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_data  in  DATA_WIDTH  signed in-phase sample
- q_data  in  DATA_WIDTH  signed quadrature sample
- valid  in  1  sample strobe, any duty cycle
- sqrt_x  out  X_WIDTH  mean power to square-root stage
- sqrt_en  out  1  one-cycle start pulse to square-root stage
- sqrt_dav  in  1  one-cycle done pulse from square-root stage
- busy  out  1  high while waiting for sqrt_dav
- overrun  out  1  sticky: a pending mean was overwritten
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset: all outputs 0, accumulator 0, sample counter 0, pending 0, FSM IDLE.
- Datapath pipeline (registered; stages advance with valid):
  - Cycle 1 after valid: registered squares I^2, Q^2, unsigned 2*DATA_WIDTH bits. -2^(DW-1) squared = 2^(2DW-2) must not overflow.
  - Cycle 2: sum = I^2 + Q^2, 2*DATA_WIDTH bits. Maximum 2^(2DW-1) fits.
  - Cycle 3: accumulator (2*DATA_WIDTH+LOG2_AVG bits) += sum; sample counter increments.
- Last sample of a block (counter = 2^LOG2_AVG-1):
  - mean = (acc + sum) >> LOG2_AVG, truncated, zero-extended/trimmed to X_WIDTH, loaded into the holding register.
  - Accumulator and counter clear on the same edge; pending set. There is no gap between blocks.
- Dispatch FSM:
  - IDLE: if pending, next edge sqrt_x <= holding, sqrt_en <= 1 for exactly one cycle, pending cleared, goto WAIT.
  - WAIT: busy = 1; sqrt_en held 0; on sqrt_dav goto IDLE.
  - sqrt_x holds its value until the next dispatch.
- Latency: valid of a block's last sample at edge 0 -> sqrt_en high after edge 4 (IDLE, nothing pending).
- Pending/overrun rules:
  - New mean arrives while pending = 1 and not consumed that cycle: holding is overwritten by the newest mean, overrun <= 1.
  - New mean on the same cycle pending is consumed by dispatch: holding takes the new mean, pending stays 1, no overrun.
  - overrun_clr and a new overrun on the same cycle: overrun stays 1.
- sqrt_dav in IDLE is ignored.
- sqrt_en is never asserted in WAIT; the downstream stage cancels on en.
- Reset mid-block or mid-WAIT:
  - Partial block discarded, FSM IDLE.
  - A later stray sqrt_dav is ignored.

Optional Feature:
- Macro IQ_POWER_AVG_ROUND_EN.
- Defined:
  - mean = (acc + sum + 2^(LOG2_AVG-1)) >> LOG2_AVG, i.e. round half up.
  - Result saturates to all-ones X_WIDTH if the rounded value exceeds it.
  - LOG2_AVG = 0 adds nothing.
- Undefined: truncation as above.
- Latency identical either way.

Test Plan:
- Reset: after rst, drive random inputs with valid low -> sqrt_en, busy, overrun, sqrt_x all 0.
- LOG2_AVG=2, four valids I=3, Q=4; dav modelled 17 cycles after en ->
  - sqrt_x = 25, single sqrt_en pulse 4 cycles after the 4th valid.
  - busy high until dav, then IDLE.
- Extremes, four samples I=Q=-32768 -> sqrt_x = 0x80000000, no wrap.
- Truncation, samples (1,0),(1,0),(1,0),(0,0) -> sqrt_x = 0; with IQ_POWER_AVG_ROUND_EN -> sqrt_x = 1.
- Overrun, 12 back-to-back valids (I=1,2,3 per block, Q=0), dav withheld ->
  - Exactly one en, carrying 1.
  - Third mean (9) overwrites second (4); overrun = 1.
  - After dav, next en carries 9.
  - overrun_clr -> overrun = 0.
- Reset asserted during WAIT, then dav pulse -> no sqrt_en; busy = 0; next full block dispatches normally.
